// File: rtl/spi_master_param.sv
// SPI master with configurable width, SCK divider, CS setup/hold, run-time CPOL/CPHA/bit order and held-CS bursts.
// Optional macro SPI_MISO_RDY_WAIT_EN inserts a miso-low ready wait (with timeout) before every word.
module spi_master_param #(
   parameter int DATA_W      = 8,
   parameter int CLK_DIV     = 4,
   parameter int CS_N        = 1,
   parameter int CS_SETUP    = 2,
   parameter int CS_HOLD     = 2,
   parameter int RDY_TIMEOUT = 1024,
   localparam int SEL_W      = (CS_N > 1) ? $clog2(CS_N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic [SEL_W-1:0]  cs_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic              hold_cs,
   input  logic              miso,
   output logic              mosi,
   output logic              sck,
   output logic [CS_N-1:0]   cs_n,
   output logic              busy,
   output logic [DATA_W-1:0] data_out,
   output logic              new_data,
   output logic              chip_rdy
);
   localparam int M1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int M2   = (M1 > CS_HOLD) ? M1 : CS_HOLD;
   localparam int CMAX = (M2 > RDY_TIMEOUT) ? M2 : RDY_TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int EW   = $clog2(2*DATA_W + 1);

`ifdef SPI_MISO_RDY_WAIT_EN
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_XFER, S_HOLD} state_t;
   localparam state_t S_POST = S_WAIT;
`else
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;
   localparam state_t S_POST = S_XFER;
`endif

   state_t            state, next;
   logic [CW-1:0]     cnt;
   logic [EW-1:0]     edge_cnt;
   logic [DATA_W-1:0] tx_sr, rx_sr, tx_src;
   logic [SEL_W-1:0]  sel_q;
   logic              cpol_q, cpha_q, lsb_q, hold_q, cs_held, timed_out;
   logic              direct, tick, edges_done, lead, do_sample, do_shift;
   logic              enter_xfer, lsb_src, hold_end;

   // Active-low decode; an out-of-range index selects nothing.
   function automatic logic [CS_N-1:0] cs_dec(input logic [SEL_W-1:0] s);
      for (int i = 0; i < CS_N; i++) cs_dec[i] = (s != SEL_W'(i));
   endfunction

   assign direct     = cs_held && (cs_sel == sel_q);
   assign tick       = (state == S_XFER) && (cnt == CW'(CLK_DIV - 1));
   assign edges_done = (edge_cnt == EW'(2*DATA_W));
   assign lead       = ~edge_cnt[0];
   assign do_sample  = tick && !edges_done && (cpha_q ? !lead : lead);
   // cpha=0 skips the final trailing edge, cpha=1 skips the first leading edge.
   assign do_shift   = tick && !edges_done &&
                       (cpha_q ? (lead && edge_cnt != '0) : (!lead && edge_cnt != EW'(2*DATA_W - 1)));
   assign hold_end   = (state == S_HOLD) && (cnt == CW'(CS_HOLD - 1));
   assign enter_xfer = (next == S_XFER) && (state != S_XFER);
   assign tx_src     = (state == S_IDLE) ? data_in : tx_sr;
   assign lsb_src    = (state == S_IDLE) ? lsb_first : lsb_q;

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         S_IDLE:  if (start) next = direct ? S_POST : S_SETUP;
         S_SETUP: if (cnt == CW'(CS_SETUP - 1)) next = S_POST;
`ifdef SPI_MISO_RDY_WAIT_EN
         S_WAIT: begin
            if (!miso)                                next = S_XFER;
            else if (cnt == CW'(RDY_TIMEOUT - 1))     next = S_HOLD;
         end
`endif
         S_XFER:  if (edges_done) next = S_HOLD;
         S_HOLD:  if (hold_end) next = S_IDLE;
         default: next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt       <= '0;
         edge_cnt  <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         sel_q     <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         lsb_q     <= 1'b0;
         hold_q    <= 1'b0;
         cs_held   <= 1'b0;
         timed_out <= 1'b0;
         mosi      <= 1'b0;
         sck       <= 1'b0;
         cs_n      <= '1;
         busy      <= 1'b0;
         data_out  <= '0;
         new_data  <= 1'b0;
`ifdef SPI_MISO_RDY_WAIT_EN
         chip_rdy  <= 1'b0;
`else
         chip_rdy  <= 1'b1;
`endif
      end else begin
         new_data <= 1'b0;
         // One counter serves setup, ready-wait, SCK divider and hold phases.
         cnt <= (state != next || state == S_IDLE || tick) ? '0 : cnt + CW'(1);
         case (state)
            S_IDLE: begin
               sck <= cpol_q;
               if (start) begin
                  busy      <= 1'b1;
                  sck       <= cpol;
                  sel_q     <= cs_sel;
                  cpol_q    <= cpol;
                  cpha_q    <= cpha;
                  lsb_q     <= lsb_first;
                  hold_q    <= hold_cs;
                  tx_sr     <= data_in;
                  timed_out <= 1'b0;
`ifdef SPI_MISO_RDY_WAIT_EN
                  chip_rdy  <= 1'b0;
`endif
                  if (!direct) begin
                     cs_held <= 1'b0;
                     cs_n    <= cs_dec(cs_sel);
                  end
               end
            end
`ifdef SPI_MISO_RDY_WAIT_EN
            S_WAIT: begin
               if (!miso)               chip_rdy  <= 1'b1;
               else if (next == S_HOLD) timed_out <= 1'b1;
            end
`endif
            S_XFER: begin
               if (edges_done) begin
                  data_out <= rx_sr;
                  new_data <= 1'b1;
               end else if (tick) begin
                  sck      <= ~sck;
                  edge_cnt <= edge_cnt + EW'(1);
               end
            end
            S_HOLD: begin
               if (hold_end) begin
                  busy <= 1'b0;
                  if (hold_q && !timed_out) cs_held <= 1'b1;
                  else begin
                     cs_held <= 1'b0;
                     cs_n    <= '1;
                  end
               end
            end
            default: ;
         endcase
         if (do_sample)
            rx_sr <= lsb_q ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
         if (do_shift) begin
            mosi  <= lsb_q ? tx_sr[0] : tx_sr[DATA_W-1];
            tx_sr <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
         end
         if (enter_xfer) begin
            edge_cnt <= '0;
            mosi     <= lsb_src ? tx_src[0] : tx_src[DATA_W-1];
            tx_sr    <= lsb_src ? (tx_src >> 1) : (tx_src << 1);
         end
      end
   end
endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: reset, SPI modes, bit order, held-CS burst, busy/reset abort, ready wait.
module tb_spi_master_param;
   localparam int DW = 8, CD = 2, CSN = 4, SU = 2, HD = 2, TO = 16;

   logic           clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic           cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, hold_cs = 1'b0;
   logic           miso_drv = 1'b1, loop = 1'b0;
   logic [DW-1:0]  data_in = '0;
   logic [1:0]     cs_sel = '0;
   logic           miso, mosi, sck, busy, new_data, chip_rdy;
   logic [CSN-1:0] cs_n;
   logic [DW-1:0]  data_out;

   int tests = 0, fails = 0, rdy_at = -1;

   logic           sck_t[0:63], mosi_t[0:63], busy_t[0:63], nd_t[0:63], rdy_t[0:63];
   logic [CSN-1:0] csn_t[0:63];
   logic [DW-1:0]  dout_t[0:63];

   assign miso = loop ? mosi : miso_drv;

   spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .CS_N(CSN), .CS_SETUP(SU),
                      .CS_HOLD(HD), .RDY_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cs_sel(cs_sel),
      .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .hold_cs(hold_cs),
      .miso(miso), .mosi(mosi), .sck(sck), .cs_n(cs_n), .busy(busy),
      .data_out(data_out), .new_data(new_data), .chip_rdy(chip_rdy));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rec(input int c);
      sck_t[c] = sck; mosi_t[c] = mosi; busy_t[c] = busy; nd_t[c] = new_data;
      rdy_t[c] = chip_rdy; csn_t[c] = cs_n; dout_t[c] = data_out;
   endtask

   // Start is high during cycle 0; trace index c holds the registered outputs of cycle c.
   task automatic run_word(input logic [DW-1:0] d, input logic [1:0] sel, input logic pol,
                           input logic pha, input logic lsb, input logic hld, input int ncyc);
      data_in = d; cs_sel = sel; cpol = pol; cpha = pha; lsb_first = lsb; hold_cs = hld;
      start = 1'b1;
      rec(0);
      for (int c = 1; c <= ncyc; c++) begin
         step();
         if (c == 1) start = 1'b0;
         if (rdy_at >= 0) begin
            loop = (c >= rdy_at);
            miso_drv = 1'b1;
         end
         rec(c);
      end
   endtask

   // Number of cycles where an sck change disagrees with edges at e+k*CD, k=1..2*DW.
   function automatic int sck_bad(input int e, input int ncyc);
      int bad = 0;
      for (int c = 2; c <= ncyc; c++) begin
         logic chg, exp_chg;
         chg = (sck_t[c] !== sck_t[c-1]);
         exp_chg = (c >= e + CD) && (c <= e + 2*DW*CD) && ((c - e) % CD == 0);
         if (chg != exp_chg) bad++;
      end
      return bad;
   endfunction

   function automatic int nd_count(input int ncyc);
      int n = 0;
      for (int c = 1; c <= ncyc; c++) if (nd_t[c] === 1'b1) n++;
      return n;
   endfunction

   task automatic test_reset();
      logic exp_rdy;
`ifdef SPI_MISO_RDY_WAIT_EN
      exp_rdy = 1'b0;
`else
      exp_rdy = 1'b1;
`endif
      rst = 1'b0;
      repeat (3) step();
      tests++; if ({sck, mosi, busy, new_data} !== 4'b0000) begin
         fails++; $display("FAIL rst_ctrl: got sck/mosi/busy/nd=%b required 0000", {sck, mosi, busy, new_data}); end
      tests++; if (cs_n !== 4'hF) begin fails++; $display("FAIL rst_cs_n: got %b required 1111", cs_n); end
      tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL rst_data_out: got %h required 00", data_out); end
      tests++; if (chip_rdy !== exp_rdy) begin fails++; $display("FAIL rst_chip_rdy: got %b required %b", chip_rdy, exp_rdy); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_mode0();
      int b;
      loop = 1'b1;
      run_word(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 38);
      tests++; if (busy_t[1] !== 1'b1) begin fails++; $display("FAIL m0_busy_rise: got %b required 1", busy_t[1]); end
      tests++; if (csn_t[1] !== 4'b1110) begin fails++; $display("FAIL m0_cs_assert: got %b required 1110", csn_t[1]); end
      tests++; if (mosi_t[3] !== 1'b1) begin fails++; $display("FAIL m0_first_bit: got %b required 1", mosi_t[3]); end
      b = sck_bad(3, 38);
      tests++; if (b !== 0) begin fails++; $display("FAIL m0_sck_edges: got %0d bad cycles required 0", b); end
      tests++; if (nd_t[36] !== 1'b1 || nd_count(38) !== 1) begin
         fails++; $display("FAIL m0_new_data: got nd36=%b count=%0d required 1/1", nd_t[36], nd_count(38)); end
      tests++; if (dout_t[36] !== 8'hA5) begin fails++; $display("FAIL m0_data_out: got %h required a5", dout_t[36]); end
      tests++; if (busy_t[37] !== 1'b1 || busy_t[38] !== 1'b0) begin
         fails++; $display("FAIL m0_busy_fall: got b37=%b b38=%b required 1/0", busy_t[37], busy_t[38]); end
      tests++; if (csn_t[38] !== 4'hF) begin fails++; $display("FAIL m0_cs_release: got %b required 1111", csn_t[38]); end
   endtask

   task automatic test_mode3_lsb();
      int b, mb;
      loop = 1'b0; miso_drv = 1'b1;
      run_word(8'h01, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 38);
      tests++; if (sck_t[2] !== 1'b1) begin fails++; $display("FAIL m3_sck_idle: got %b required 1", sck_t[2]); end
      tests++; if (mosi_t[3] !== 1'b1 || mosi_t[6] !== 1'b1) begin
         fails++; $display("FAIL m3_first_bit: got %b%b required 11", mosi_t[3], mosi_t[6]); end
      mb = 0;
      for (int j = 1; j < DW; j++) if (mosi_t[6 + 4*j] !== 1'b0) mb++;
      tests++; if (mb !== 0) begin fails++; $display("FAIL m3_later_bits: got %0d nonzero bits required 0", mb); end
      b = sck_bad(3, 38);
      tests++; if (b !== 0) begin fails++; $display("FAIL m3_sck_edges: got %0d bad cycles required 0", b); end
      tests++; if (dout_t[36] !== 8'hFF || nd_t[36] !== 1'b1) begin
         fails++; $display("FAIL m3_data_out: got %h nd=%b required ff/1", dout_t[36], nd_t[36]); end
      tests++; if (sck_t[36] !== 1'b1) begin fails++; $display("FAIL m3_sck_rest: got %b required 1", sck_t[36]); end
   endtask

   task automatic test_mode1_lsb();
      loop = 1'b1;
      run_word(8'h4B, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 38);
      tests++; if (csn_t[1] !== 4'b1101) begin fails++; $display("FAIL m1_cs_sel: got %b required 1101", csn_t[1]); end
      tests++; if (mosi_t[3] !== 1'b1 || mosi_t[14] !== 1'b0) begin
         fails++; $display("FAIL m1_bit_order: got %b%b required 10", mosi_t[3], mosi_t[14]); end
      tests++; if (dout_t[36] !== 8'h4B) begin fails++; $display("FAIL m1_data_out: got %h required 4b", dout_t[36]); end
   endtask

   task automatic test_burst();
      int n1, b;
      loop = 1'b1;
      run_word(8'h3C, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 38);
      n1 = nd_count(38);
      tests++; if (csn_t[1] !== 4'b1011 || dout_t[36] !== 8'h3C) begin
         fails++; $display("FAIL bu_word1: got cs=%b dout=%h required 1011/3c", csn_t[1], dout_t[36]); end
      tests++; if (csn_t[38] !== 4'b1011 || busy_t[38] !== 1'b0) begin
         fails++; $display("FAIL bu_cs_held: got cs=%b busy=%b required 1011/0", csn_t[38], busy_t[38]); end
      run_word(8'hC3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 36);
      tests++; if (busy_t[1] !== 1'b1 || mosi_t[1] !== 1'b1 || csn_t[1] !== 4'b1011) begin
         fails++; $display("FAIL bu_skip_setup: got busy=%b mosi=%b cs=%b required 1/1/1011", busy_t[1], mosi_t[1], csn_t[1]); end
      b = sck_bad(1, 36);
      tests++; if (b !== 0) begin fails++; $display("FAIL bu_sck_edges: got %0d bad cycles required 0", b); end
      tests++; if (nd_t[34] !== 1'b1 || dout_t[34] !== 8'hC3) begin
         fails++; $display("FAIL bu_word2: got nd=%b dout=%h required 1/c3", nd_t[34], dout_t[34]); end
      tests++; if (csn_t[35] !== 4'b1011 || csn_t[36] !== 4'hF || busy_t[36] !== 1'b0) begin
         fails++; $display("FAIL bu_release: got cs35=%b cs36=%b busy=%b required 1011/1111/0", csn_t[35], csn_t[36], busy_t[36]); end
      tests++; if (n1 + nd_count(36) !== 2) begin
         fails++; $display("FAIL bu_pulses: got %0d required 2", n1 + nd_count(36)); end
   endtask

   task automatic test_busy_reset();
      int extra;
      loop = 1'b1;
      data_in = 8'hFF; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; hold_cs = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c == 1) start = 1'b0;
         if (c == 6) begin start = 1'b1; cs_sel = 2'd1; end
         if (c == 7) begin
            start = 1'b0;
            tests++; if (cs_n !== 4'b1110 || busy !== 1'b1) begin
               fails++; $display("FAIL br_ignored: got cs=%b busy=%b required 1110/1", cs_n, busy); end
         end
      end
      tests++; if (sck !== 1'b1) begin fails++; $display("FAIL br_sck_mid: got %b required 1", sck); end
      rst = 1'b0;
      step();
      tests++; if (sck !== 1'b0 || cs_n !== 4'hF || busy !== 1'b0 || new_data !== 1'b0) begin
         fails++; $display("FAIL br_abort: got sck=%b cs=%b busy=%b nd=%b required 0/1111/0/0", sck, cs_n, busy, new_data); end
      rst = 1'b1;
      extra = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (new_data !== 1'b0 || busy !== 1'b0) extra++;
      end
      tests++; if (extra !== 0) begin fails++; $display("FAIL br_quiet: got %0d active cycles required 0", extra); end
   endtask

`ifdef SPI_MISO_RDY_WAIT_EN
   task automatic test_rdy_ok();
      int b;
      loop = 1'b0; miso_drv = 1'b1; rdy_at = 8;
      run_word(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 44);
      rdy_at = -1;
      tests++; if (rdy_t[8] !== 1'b0 || rdy_t[9] !== 1'b1) begin
         fails++; $display("FAIL ro_chip_rdy: got r8=%b r9=%b required 0/1", rdy_t[8], rdy_t[9]); end
      tests++; if (mosi_t[8] !== 1'b0 || mosi_t[9] !== 1'b1) begin
         fails++; $display("FAIL ro_xfer_entry: got m8=%b m9=%b required 0/1", mosi_t[8], mosi_t[9]); end
      b = sck_bad(9, 44);
      tests++; if (b !== 0) begin fails++; $display("FAIL ro_sck_edges: got %0d bad cycles required 0", b); end
      tests++; if (nd_t[42] !== 1'b1 || dout_t[42] !== 8'hA5 || busy_t[44] !== 1'b0) begin
         fails++; $display("FAIL ro_done: got nd=%b dout=%h busy=%b required 1/a5/0", nd_t[42], dout_t[42], busy_t[44]); end
   endtask

   task automatic test_rdy_timeout();
      loop = 1'b0; miso_drv = 1'b1; rdy_at = 1000;
      run_word(8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 30);
      rdy_at = -1;
      tests++; if (rdy_t[1] !== 1'b0 || rdy_t[21] !== 1'b0) begin
         fails++; $display("FAIL to_chip_rdy: got r1=%b r21=%b required 0/0", rdy_t[1], rdy_t[21]); end
      tests++; if (busy_t[20] !== 1'b1 || busy_t[21] !== 1'b0) begin
         fails++; $display("FAIL to_busy_fall: got b20=%b b21=%b required 1/0", busy_t[20], busy_t[21]); end
      tests++; if (csn_t[21] !== 4'hF) begin fails++; $display("FAIL to_cs_release: got %b required 1111", csn_t[21]); end
      tests++; if (nd_count(30) !== 0 || dout_t[21] !== 8'hA5) begin
         fails++; $display("FAIL to_no_data: got count=%0d dout=%h required 0/a5", nd_count(30), dout_t[21]); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef SPI_MISO_RDY_WAIT_EN
      test_rdy_ok();
      test_rdy_timeout();
`else
      test_mode0();
      test_mode3_lsb();
      test_mode1_lsb();
      test_burst();
      test_busy_reset();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
